// File: rtl/fu_pkg.sv
// Shared definitions for the execute-stage functional unit controller:
// funct codes, FSM state encoding and the default datapath width.
package fu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ALU  = 2'b01,
    ST_MUL  = 2'b10,
    ST_FIN  = 2'b11
  } state_t;

  function automatic logic is_alu_op(input logic [5:0] f);
    return (f == FN_AND) || (f == FN_OR) || (f == FN_ADD) ||
           (f == FN_SUB) || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/multu_core.sv
// Iterative shift-add unsigned multiplier owning HI/LO, the multiplicand
// register and the iteration counter; one iteration per step cycle.
module multu_core
  import fu_pkg::*;
#(
  parameter int WIDTH     = fu_pkg::WIDTH,
  parameter int MUL_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MUL_ITERS) + 1;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  // {C,HI} = HI + (LO[0] ? mcand : 0), then {C,HI,LO} shifts right by one
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    if (load) begin
      hi_d    = '0;
      lo_d    = opa;
      mcand_d = opb;
      cnt_d   = '0;
    end else if (step) begin
      hi_d  = sum[WIDTH:1];
      lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(MUL_ITERS - 1));
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/funct_unit_ctrl.sv
// Execute-stage issue/sequencing controller: drives the shared ALU for
// single-cycle ops, runs MULTU internally and serves MFHI/MFLO from HI/LO.
module funct_unit_ctrl
  import fu_pkg::*;
#(
  parameter int WIDTH     = fu_pkg::WIDTH,
  parameter int MUL_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [5:0]       alu_signal,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  state_t state_q, state_d;

  logic [5:0]       alu_signal_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  logic             accept;
  logic             mul_load, mul_step, mul_last;
  logic [WIDTH-1:0] hi, lo;

  assign accept = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_alu_op(funct))      state_d = ST_ALU;
          else if (funct == FN_MULTU) state_d = ST_MUL;
          else                       state_d = ST_FIN;
        end
      end
      ST_ALU:  state_d = ST_FIN;
      ST_MUL:  if (mul_last) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: mul_load = start && (funct == FN_MULTU);
      ST_ALU:  busy = 1'b1;
      ST_MUL: begin
        busy     = 1'b1;
        mul_step = 1'b1;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // ALU drive registers double as the latched operands; they hold when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_signal_q <= 6'b000000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
      case (funct)
        FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: begin
          alu_signal_q <= funct;
          alu_a_q      <= opA;
          alu_b_q      <= opB;
        end
        FN_MULTU: result_q <= '0;
        FN_MFHI:  result_q <= hi;
        FN_MFLO:  result_q <= lo;
        default: begin
          result_q <= '0;
          err_q    <= 1'b1;
        end
      endcase
    end else if (state_q == ST_ALU) begin
      result_q <= alu_out;
    end else if (state_q == ST_MUL) begin
      result_q <= '0;
    end
  end

  multu_core #(
    .WIDTH    (WIDTH),
    .MUL_ITERS(MUL_ITERS)
  ) u_multu (
    .clk  (clk),
    .reset(reset),
    .load (mul_load),
    .step (mul_step),
    .opa  (opA),
    .opb  (opB),
    .last (mul_last),
    .hi   (hi),
    .lo   (lo)
  );

  assign alu_signal = alu_signal_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign result     = result_q;
  assign err        = err_q;

endmodule

// File: doc/funct_unit_ctrl.md
Name: funct_unit_ctrl

Overview:
- Issue/sequencing controller for the execute stage.
- Accepts one R-type funct code plus operands per start handshake.
- Single-cycle ops go to the shared ALU: it drives the ALU's Signal/dataA/dataB and captures the ALU result.
- MULTU runs on an internal 32-iteration shift-add unit into HI/LO; MFHI/MFLO read those registers back.
- Reports busy/done and one registered result word to the surrounding datapath.

Parameters:
- WIDTH, 32, operand/result width; HI/LO are each WIDTH bits.
- MUL_ITERS, 32, shift-add iterations for MULTU; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- funct  in  6  operation code, sampled with start.
- opA  in  32  first operand, sampled with start.
- opB  in  32  second operand, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; high when funct is unsupported.
- result  out  32  registered result; holds its value between operations.
- alu_signal  out  6  ALU operation select (Signal).
- alu_a  out  32  ALU dataA.
- alu_b  out  32  ALU dataB.
- alu_out  in  32  ALU dataOut; combinational return path.

Behaviour:
- Reset values (asynchronous, active-high): state=IDLE; busy, done, err = 0; result, HI, LO, alu_a, alu_b = 0; alu_signal = 6'b000000; iteration counter = 0.
- Supported funct codes:
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 go to the ALU.
  - MULTU 011001 is handled internally.
  - MFHI 010000 and MFLO 010010 read HI/LO.
  - Any other code is unsupported.
- States: IDLE, ALU_EXEC, MUL_RUN, FINISH.
- IDLE with start=1: latch funct, opA, opB; busy goes to 1 on the next cycle.
  - ALU op: load alu_signal/alu_a/alu_b; go to ALU_EXEC.
  - MULTU: clear HI; load LO=opA and the multiplicand register=opB; counter=0; go to MUL_RUN.
  - MFHI/MFLO: result <= HI or LO; go to FINISH.
  - Unsupported: result <= 0; err <= 1; go to FINISH.
- ALU_EXEC: exactly one cycle. result <= alu_out at the end of the cycle; go to FINISH. ALU inputs stay stable during this cycle.
- MUL_RUN, one iteration per cycle:
  - {C,HI} = HI + (LO[0] ? mcand : 0), 33-bit sum.
  - Then {HI,LO} <= {C,HI,LO} >> 1.
  - counter++. After iteration MUL_ITERS-1, go to FINISH.
  - result <= 0; the MULTU result is visible only via MFHI/MFLO.
- FINISH: done=1 and busy=0 for one cycle; go to IDLE. A start in the same cycle as done is ignored; the first acceptable start is in the following IDLE cycle.
- Latency from the accepting edge to done high:
  - ALU ops: 2 cycles.
  - MULTU: MUL_ITERS+1 cycles.
  - MFHI, MFLO, unsupported: 1 cycle.
- err: cleared on every accepted start; updates with done.
- start outside IDLE: ignored, no queuing, latched operands unchanged.
- HI/LO: written only by MULTU; persist across other operations.
- Reset mid-MULTU: HI/LO return to 0 and the partial product is discarded.
- While idle, alu_* outputs hold their last values; the ALU may be shared combinationally by other logic only when busy=0.

Decomposition:
- Shared package fu_pkg:
  - funct localparams: FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_MULTU, FN_MFHI, FN_MFLO.
  - State encoding (2-bit): IDLE=00, ALU_EXEC=01, MUL_RUN=10, FINISH=11.
  - WIDTH default.
- One sub-module, multu_core:
  - Owns HI, LO, the multiplicand register, the counter and the 33-bit adder.
  - Ports: load, step, last, HI, LO.
- funct_unit_ctrl keeps the FSM, ALU drive and result/err registers.

Test Plan:
- ADD opA=5, opB=7 -> alu_signal=100000 during ALU_EXEC; done at +2 cycles; result=0x0000000C; err=0.
- SUB opA=3, opB=5, then SLT opA=0xFFFFFFFF, opB=1 -> results 0xFFFFFFFE then 0x00000001 (ALU-defined signed compare).
- MULTU opA=opB=0xFFFFFFFF -> done at +33 cycles. Then MFHI -> 0xFFFFFFFE at +1 cycle; MFLO -> 0x00000001.
- MULTU opA=0x00010000, opB=0x00010000 -> MFHI=0x00000001, MFLO=0x00000000. Additionally, start=1 with funct=ADD held through the whole MULTU -> ignored: exactly one done, HI/LO unchanged.
- MULTU 3×4, assert reset at iteration 10 -> busy=0 and done=0 immediately; after reset, MFHI and MFLO return 0.
- funct=111111 -> done at +1 cycle; err=1; result=0. Next ADD 1+1 -> err=0; result=2.
